// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - multi-cycle restoring divider with quotient/remainder, N/Z and divide-by-zero flags
// Optional signed division is compiled in with `define SIGNED_DIV_EN.
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             N,
  output logic             Z,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] q_fin, r_fin;
  logic             accept;

  assign accept = (state_q == IDLE) && start && (B != '0);

  // One restoring step: shift {rem,quo} left, subtract divisor when it fits.
  always_comb begin
    rem_sh   = {rem_q, quo_q[WIDTH-1]};
    rem_step = rem_sh[WIDTH:0];
    quo_step = {quo_q[WIDTH-2:0], 1'b0};
    if (rem_sh >= {2'b00, div_q}) begin
      rem_step    = rem_sh[WIDTH:0] - {1'b0, div_q};
      quo_step[0] = 1'b1;
    end
  end

`ifdef SIGNED_DIV_EN
  logic a_neg, b_neg;
  logic neg_q_q, neg_q_d;
  logic neg_r_q, neg_r_d;

  assign a_neg = is_signed & A[WIDTH-1];
  assign b_neg = is_signed & B[WIDTH-1];
  assign a_mag = a_neg ? (~A + 1'b1) : A;
  assign b_mag = b_neg ? (~B + 1'b1) : B;

  always_comb begin
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    if (accept) begin
      neg_q_d = a_neg ^ b_neg;
      neg_r_d = a_neg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end

  // Truncating division: quotient sign from operand signs, remainder follows the dividend.
  assign q_fin = neg_q_q ? (~quo_step + 1'b1) : quo_step;
  assign r_fin = neg_r_q ? (~rem_step[WIDTH-1:0] + 1'b1) : rem_step[WIDTH-1:0];
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_mag = A;
  assign b_mag = B;
  assign q_fin = quo_step;
  assign r_fin = rem_step[WIDTH-1:0];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    q_d     = q_q;
    r_d     = r_q;
    n_d     = n_q;
    z_d     = z_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (B == '0) begin
            q_d     = '1;
            r_d     = A;
            n_d     = 1'b1;
            z_d     = 1'b0;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            div_d   = b_mag;
            cnt_d   = CW'(WIDTH);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_step;
        quo_d = quo_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          q_d     = q_fin;
          r_d     = r_fin;
          n_d     = q_fin[WIDTH-1];
          z_d     = (q_fin == '0);
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      q_q     <= q_d;
      r_q     <= r_d;
      n_q     <= n_d;
      z_q     <= z_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign Q    = q_q;
  assign R    = r_q;
  assign N    = n_q;
  assign Z    = z_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_alu_divider.sv
// tb/tb_alu_divider.sv - directed self-checking bench for alu_divider (WIDTH=32)
module tb_alu_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        is_signed = 1'b0;
  logic        busy, done, n, z, dbz;
  logic [31:0] q, r;

  int checks = 0;
  int failures = 0;

  alu_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .is_signed(is_signed),
    .busy(busy), .done(done), .Q(q), .R(r), .N(n), .Z(z), .dbz(dbz)
  );

  always #5 clk = ~clk;

  // Issues one request and returns the cycle count at which done was first seen (1 = right after accept).
  task automatic run_div(input logic [31:0] a_i, input logic [31:0] b_i, input logic s_i,
                         output int cyc);
    @(negedge clk);
    a = a_i; b = b_i; is_signed = s_i; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, done, n, z, dbz} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=00000", {busy, done, n, z, dbz});
    end
    checks++;
    if (q !== 32'd0 || r !== 32'd0) begin
      failures++;
      $display("FAIL reset_qr got Q=%h R=%h want 0/0", q, r);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    int cyc;
    run_div(32'd100, 32'd7, 1'b0, cyc);
    checks++;
    if (cyc !== 33) begin failures++; $display("FAIL lat_100_7 got=%0d want=33", cyc); end
    checks++;
    if (q !== 32'd14 || r !== 32'd2) begin
      failures++; $display("FAIL div_100_7 got Q=%0d R=%0d want 14/2", q, r);
    end
    checks++;
    if ({n, z, dbz} !== 3'b000) begin
      failures++; $display("FAIL flags_100_7 got=%b want=000", {n, z, dbz});
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL done_pulse got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_div_by_zero;
    int cyc;
    run_div(32'd5, 32'd0, 1'b0, cyc);
    checks++;
    if (cyc !== 1) begin failures++; $display("FAIL lat_dbz got=%0d want=1", cyc); end
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd5) begin
      failures++; $display("FAIL div_5_0 got Q=%h R=%h want ffffffff/5", q, r);
    end
    checks++;
    if ({n, z, dbz} !== 3'b101) begin
      failures++; $display("FAIL flags_dbz got=%b want=101", {n, z, dbz});
    end
  endtask

  task automatic test_zero_and_max;
    int cyc;
    run_div(32'd0, 32'd3, 1'b0, cyc);
    checks++;
    if (q !== 32'd0 || r !== 32'd0 || {n, z, dbz} !== 3'b010) begin
      failures++; $display("FAIL div_0_3 got Q=%h R=%h NZD=%b want 0/0/010", q, r, {n, z, dbz});
    end
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, cyc);
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'd0 || {n, z, dbz} !== 3'b100) begin
      failures++; $display("FAIL div_max_1 got Q=%h R=%h NZD=%b want ffffffff/0/100", q, r, {n, z, dbz});
    end
  endtask

  task automatic test_start_while_busy;
    int cyc;
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (cyc == 5) begin
        checks++;
        if (q !== 32'hFFFF_FFFF) begin
          failures++; $display("FAIL q_hold got=%h want=ffffffff", q);
        end
      end
      if (cyc == 10) begin
        start = 1'b1; a = 32'd9; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc !== 33 || q !== 32'd14 || r !== 32'd2) begin
      failures++; $display("FAIL busy_ignore got cyc=%0d Q=%0d R=%0d want 33/14/2", cyc, q, r);
    end
  endtask

  task automatic test_reset_mid_calc;
    int cyc;
    bit seen_done;
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || q !== 32'd0 || r !== 32'd0) begin
      failures++; $display("FAIL mid_reset got busy=%b Q=%h R=%h want 0/0/0", busy, q, r);
    end
    seen_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin failures++; $display("FAIL mid_reset_done got=1 want=0"); end
    run_div(32'd9, 32'd3, 1'b0, cyc);
    checks++;
    if (cyc !== 33 || q !== 32'd3 || r !== 32'd0) begin
      failures++; $display("FAIL after_reset got cyc=%0d Q=%0d R=%0d want 33/3/0", cyc, q, r);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    @(negedge clk);
    a = 32'd9; b = 32'd3; start = 1'b1;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (q !== 32'd3 || r !== 32'd0) begin
      failures++; $display("FAIL b2b_first got Q=%0d R=%0d want 3/0", q, r);
    end
    a = 32'd20; b = 32'd6;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 33 || q !== 32'd3 || r !== 32'd2) begin
      failures++; $display("FAIL b2b_second got cyc=%0d Q=%0d R=%0d want 33/3/2", cyc, q, r);
    end
  endtask

`ifdef SIGNED_DIV_EN
  task automatic test_signed;
    int cyc;
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, cyc);
    checks++;
    if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || n !== 1'b1) begin
      failures++; $display("FAIL sdiv_m7_2 got Q=%h R=%h N=%b want fffffffd/ffffffff/1", q, r, n);
    end
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, cyc);
    checks++;
    if (q !== 32'h8000_0000 || r !== 32'd0 || dbz !== 1'b0) begin
      failures++; $display("FAIL sdiv_min_m1 got Q=%h R=%h dbz=%b want 80000000/0/0", q, r, dbz);
    end
    run_div(32'hFFFF_FFFB, 32'd0, 1'b1, cyc);
    checks++;
    if (q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFFB || dbz !== 1'b1) begin
      failures++; $display("FAIL sdiv_dbz got Q=%h R=%h dbz=%b want ffffffff/fffffffb/1", q, r, dbz);
    end
  endtask
`else
  task automatic test_signed;
    int cyc;
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, cyc);
    checks++;
    if (q !== 32'h7FFF_FFFC || r !== 32'd1 || n !== 1'b0) begin
      failures++; $display("FAIL is_signed_ignored got Q=%h R=%h N=%b want 7ffffffc/1/0", q, r, n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_div_by_zero();
    test_zero_and_max();
    test_start_while_busy();
    test_reset_mid_calc();
    test_back_to_back();
    test_signed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
